// File: rtl/ctx_stack_ctrl.sv
// Context-save sequencer: frame pointer, snapshot-stack addr/wren, return-PC stack, restore strobes.
// Latency: CALL done 2 cycles after the accepting cycle, RET done 3 cycles after; all outputs registered.
// Backpressure: requests are sampled only in IDLE; requests while busy or in DONE are dropped, not queued.
// Optional build macro STACK_ERR_STICKY_EN: ovf/unf latch until err_clr_i instead of pulsing.

module ctx_stack_ctrl #(
  parameter int ADDR_W = 6,
  parameter int PC_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              call_req_i,
  input  logic              ret_req_i,
  input  logic [PC_W-1:0]   pc_in_i,
  input  logic              err_clr_i,
  output logic [ADDR_W-1:0] stk_addr_o,
  output logic              stk_wren_o,
  output logic              reg_restore_o,
  output logic              pc_load_o,
  output logic [PC_W-1:0]   pc_out_o,
  output logic [ADDR_W-1:0] sp_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              unf_o
);

  // Highest usable slot; slot 0 is the empty base and is never written.
  localparam logic [ADDR_W-1:0] SP_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH   = 3'd1,
    S_POP_RD = 3'd2,
    S_POP_LD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] stk_addr_q;
  logic              stk_wren_q;
  logic              reg_restore_q;
  logic              pc_load_q;
  logic [PC_W-1:0]   pc_out_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic              unf_q;
  logic [PC_W-1:0]   pc_lat_q;

  // Return-PC array, indexed by frame number; deliberately not reset.
  logic [PC_W-1:0]   rpc_q [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] sp_inc_d;
  logic [ADDR_W-1:0] sp_dec_d;
  logic              idle_d;
  logic              call_ok_d;
  logic              ret_ok_d;
  logic              ovf_hit_d;
  logic              unf_hit_d;

  // Request qualification: CALL beats RET, and each is checked against its stack boundary.
  always_comb begin
    sp_inc_d  = sp_q + ADDR_W'(1);
    sp_dec_d  = sp_q - ADDR_W'(1);
    idle_d    = (state_q == S_IDLE);
    call_ok_d = idle_d && call_req_i && (sp_q != SP_MAX);
    ovf_hit_d = idle_d && call_req_i && (sp_q == SP_MAX);
    ret_ok_d  = idle_d && !call_req_i && ret_req_i && (sp_q != '0);
    unf_hit_d = idle_d && !call_req_i && ret_req_i && (sp_q == '0);
  end

  // Return-PC capture into the new top slot while the snapshot push is in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_PUSH) begin
      rpc_q[sp_inc_d] <= pc_lat_q;
    end
  end

  // Sequencer FSM with registered outputs; reset aborts any operation in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      sp_q          <= '0;
      stk_addr_q    <= '0;
      stk_wren_q    <= 1'b0;
      reg_restore_q <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_out_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pc_lat_q      <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      stk_wren_q    <= 1'b0;
      reg_restore_q <= 1'b0;
      pc_load_q     <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          stk_addr_q <= sp_q;
          busy_q     <= 1'b0;
          if (call_ok_d) begin
            pc_lat_q   <= pc_in_i;
            stk_addr_q <= sp_inc_d;
            stk_wren_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_PUSH;
          end else if (ret_ok_d) begin
            busy_q     <= 1'b1;
            state_q    <= S_POP_RD;
          end
        end
        S_PUSH: begin
          sp_q       <= sp_inc_d;
          stk_addr_q <= sp_inc_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_DONE;
        end
        S_POP_RD: begin
          // Stack outputs have had a cycle to settle; hand them to the core.
          stk_addr_q    <= sp_q;
          reg_restore_q <= 1'b1;
          pc_load_q     <= 1'b1;
          pc_out_q      <= rpc_q[sp_q];
          state_q       <= S_POP_LD;
        end
        S_POP_LD: begin
          sp_q       <= sp_dec_d;
          stk_addr_q <= sp_dec_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          stk_addr_q <= sp_q;
          state_q    <= S_IDLE;
        end
        default: begin
          stk_addr_q <= sp_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
`ifdef STACK_ERR_STICKY_EN
      // Sticky flags: clear wins over a fresh rejection in the same cycle.
      ovf_q <= !err_clr_i && (ovf_q || ovf_hit_d);
      unf_q <= !err_clr_i && (unf_q || unf_hit_d);
`else
      ovf_q <= ovf_hit_d;
      unf_q <= unf_hit_d;
`endif
    end
  end

`ifndef STACK_ERR_STICKY_EN
  // Error clear has no effect when the flags only pulse.
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
`endif

  assign stk_addr_o    = stk_addr_q;
  assign stk_wren_o    = stk_wren_q;
  assign reg_restore_o = reg_restore_q;
  assign pc_load_o     = pc_load_q;
  assign pc_out_o      = pc_out_q;
  assign sp_o          = sp_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign ovf_o         = ovf_q;
  assign unf_o         = unf_q;

endmodule
